// File: rtl/eth_cmd_rx_pkg.sv
// Shared constants and state encoding for the Ethernet host-command receiver.
// Header bytes and timeout here are defaults; the top module can override them.
package eth_cmd_rx_pkg;

  localparam logic [7:0] HEAD0_DEF   = 8'h55;
  localparam logic [7:0] HEAD1_DEF   = 8'hAA;
  localparam int         TIMEOUT_DEF = 1000;

  localparam int BTYPE_W = 4;
  localparam int CMD_W   = 16;
  localparam int ERR_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HD1,
    S_BTYP,
    S_CMDH,
    S_CMDL,
    S_CSUM,
    S_SEND,
    S_DONE
  } state_e;

endpackage

// File: rtl/eth_cmd_rx_if.sv
// MAC byte stream in, console fs/fd read handshake out, bundled as one port.
// master = MAC/console side, slave = the receiver.
interface eth_cmd_rx_if;
  import eth_cmd_rx_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               fs_eth_read;
  logic               fd_eth_read;
  logic [BTYPE_W-1:0] read_eth_btype;
  logic [CMD_W-1:0]   com_cmd;
  logic [ERR_W-1:0]   err_cnt;

  modport master (
    output rx_data, rx_valid, fd_eth_read,
    input  fs_eth_read, read_eth_btype, com_cmd, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid, fd_eth_read,
    output fs_eth_read, read_eth_btype, com_cmd, err_cnt
  );

endinterface

// File: rtl/eth_cmd_rx.sv
// Hunts for HEAD0/HEAD1, gathers btype + 16-bit command, verifies the XOR checksum
// and offers good frames to the console through the fs/fd handshake.
module eth_cmd_rx
  import eth_cmd_rx_pkg::*;
#(
  parameter logic [7:0] HEAD0   = HEAD0_DEF,
  parameter logic [7:0] HEAD1   = HEAD1_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  eth_cmd_rx_if.slave      bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [TW-1:0]      timer_q, timer_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [7:0]         acc_q;
  logic [BTYPE_W-1:0] btype_sh_q, btype_q;
  logic [CMD_W-1:0]   cmd_sh_q, cmd_q;
  logic               fs_q;
  logic               in_frame, timeout_hit, err_inc;

  // All drop sources funnel into one increment so coincident events count once.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    in_frame    = state_q inside {S_HD1, S_BTYP, S_CMDH, S_CMDL, S_CSUM};
    timeout_hit = in_frame && !bus.rx_valid && (timer_q == TW'(TIMEOUT - 1));

    timer_d = '0;
    if (in_frame && !bus.rx_valid && !timeout_hit) timer_d = timer_q + 1'b1;

    err_inc = timeout_hit;
    if (bus.rx_valid) begin
      case (state_q)
        S_BTYP:         if (bus.rx_data[7:4] != 4'h0) err_inc = 1'b1;
        S_CSUM:         if (bus.rx_data != acc_q)     err_inc = 1'b1;
        S_SEND, S_DONE: err_inc = 1'b1;
        default:        ;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      err_cnt_q  <= '0;
      acc_q      <= '0;
      btype_sh_q <= '0;
      cmd_sh_q   <= '0;
      btype_q    <= '0;
      cmd_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;

      if (timeout_hit) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (bus.rx_valid && bus.rx_data == HEAD0) state_q <= S_HD1;

          S_HD1: if (bus.rx_valid) begin
            if (bus.rx_data == HEAD1)      state_q <= S_BTYP;
            else if (bus.rx_data == HEAD0) state_q <= S_HD1;
            else                           state_q <= S_IDLE;
          end

          S_BTYP: if (bus.rx_valid) begin
            acc_q      <= bus.rx_data;
            btype_sh_q <= bus.rx_data[BTYPE_W-1:0];
            state_q    <= (bus.rx_data[7:4] != 4'h0) ? S_IDLE : S_CMDH;
          end

          S_CMDH: if (bus.rx_valid) begin
            cmd_sh_q[15:8] <= bus.rx_data;
            acc_q          <= acc_q ^ bus.rx_data;
            state_q        <= S_CMDL;
          end

          S_CMDL: if (bus.rx_valid) begin
            cmd_sh_q[7:0] <= bus.rx_data;
            acc_q         <= acc_q ^ bus.rx_data;
            state_q       <= S_CSUM;
          end

          // Visible outputs move only here, so they hold across bad frames and handshakes.
          S_CSUM: if (bus.rx_valid) begin
            if (bus.rx_data == acc_q) begin
              btype_q <= btype_sh_q;
              cmd_q   <= cmd_sh_q;
              fs_q    <= 1'b1;
              state_q <= S_SEND;
            end else begin
              state_q <= S_IDLE;
            end
          end

          S_SEND: if (bus.fd_eth_read) begin
            fs_q    <= 1'b0;
            state_q <= S_DONE;
          end

          S_DONE: if (!bus.fd_eth_read) state_q <= S_IDLE;

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.fs_eth_read    = fs_q;
  assign bus.read_eth_btype = btype_q;
  assign bus.com_cmd        = cmd_q;
  assign bus.err_cnt        = err_cnt_q;

endmodule
